// File: rtl/freq_counter_pkg.sv
// Shared state encoding and gate-length helpers for the power-of-two frequency counter.
package freq_counter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_GATE = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    GATE = ST_GATE
  } state_t;

  // Gate counter reload: a gate of 2^eff cycles counts down from 2^eff - 1 to 0.
  function automatic logic [63:0] pow2_minus1(input int unsigned eff);
    pow2_minus1 = (64'd1 << eff) - 64'd1;
  endfunction

  function automatic int unsigned clamp_log2N(input int unsigned log2n, input int unsigned lmax);
    clamp_log2N = (log2n > lmax) ? lmax : log2n;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for one asynchronous input, followed by a rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_counter_pow2.sv
// Gapless multi-channel frequency counter: counts rising edges per channel over
// back-to-back gates of 2^log2N clk cycles and reports each gate on a valid/ready port.
//
// state | meaning
// IDLE  | stopped; accumulators and gate counter held at zero
// GATE  | measuring; final cycle (gate counter 0) reports and reloads with no gap
module freq_counter_pow2 #(
  parameter int N_CH        = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int LOG2N_WIDTH = 5,
  parameter int LOG2N_MAX   = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [LOG2N_WIDTH-1:0]    log2N,
  input  logic [N_CH-1:0]           sig_in,
  output logic [N_CH*CNT_WIDTH-1:0] res_count,
  output logic [N_CH-1:0]           res_sat,
  output logic [LOG2N_WIDTH-1:0]    res_log2N,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      overrun,
  output logic                      busy
);

  import freq_counter_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_start;
  logic                        w_final;
  logic [LOG2N_MAX-1:0]        r_gate_cnt;
  logic [LOG2N_WIDTH-1:0]      r_eff;
  logic [LOG2N_WIDTH-1:0]      w_eff;
  logic [LOG2N_MAX-1:0]        w_reload;
  logic [N_CH-1:0]             w_edge;
  logic [CNT_WIDTH-1:0]        r_acc [N_CH];
  logic [CNT_WIDTH-1:0]        w_acc_nxt [N_CH];
  logic [N_CH-1:0]             r_sat;
  logic [N_CH-1:0]             w_sat_nxt;
  logic [N_CH*CNT_WIDTH-1:0]   r_res_count;
  logic [N_CH-1:0]             r_res_sat;
  logic [LOG2N_WIDTH-1:0]      r_res_log2N;
  logic                        r_res_valid;
  logic                        r_overrun;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    edge_sync u_edge_sync (
      .clk   (clk),
      .rst   (rst),
      .i_sig (sig_in[k]),
      .o_edge(w_edge[k])
    );
  end

  assign w_eff    = LOG2N_WIDTH'(clamp_log2N(32'(log2N), 32'(LOG2N_MAX)));
  assign w_reload = LOG2N_MAX'(pow2_minus1(32'(w_eff)));

  // Saturating add; the final-cycle edge is folded in here so the report includes it.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      if (r_acc[k] == CNT_MAX) w_acc_nxt[k] = CNT_MAX;
      else                     w_acc_nxt[k] = r_acc[k] + CNT_WIDTH'(w_edge[k]);
      w_sat_nxt[k] = r_sat[k] | (w_acc_nxt[k] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = GATE;
          w_start     = 1'b1;
        end
      end
      GATE: begin
        if (!enable)                  w_state_nxt = IDLE;
        else if (r_gate_cnt == '0)    w_final     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_eff      <= '0;
      r_sat      <= '0;
      for (int k = 0; k < N_CH; k++) r_acc[k] <= '0;
    end else begin
      if (w_start || w_final) begin
        r_gate_cnt <= w_reload;
        r_eff      <= w_eff;
      end else if (w_state_nxt == GATE) begin
        r_gate_cnt <= r_gate_cnt - 1'b1;
      end else begin
        r_gate_cnt <= '0;
      end

      if (r_state == GATE && enable && !w_final) begin
        r_sat <= w_sat_nxt;
        for (int k = 0; k < N_CH; k++) r_acc[k] <= w_acc_nxt[k];
      end else begin
        r_sat <= '0;
        for (int k = 0; k < N_CH; k++) r_acc[k] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_count <= '0;
      r_res_sat   <= '0;
      r_res_log2N <= '0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_final) begin
        for (int k = 0; k < N_CH; k++) r_res_count[k*CNT_WIDTH +: CNT_WIDTH] <= w_acc_nxt[k];
        r_res_sat   <= w_sat_nxt;
        r_res_log2N <= r_eff;
      end

      // A new result wins over a same-cycle transfer, so valid stays high.
      if (w_final)        r_res_valid <= 1'b1;
      else if (res_ready) r_res_valid <= 1'b0;

      if (!enable)                                  r_overrun <= 1'b0;
      else if (w_final && r_res_valid && !res_ready) r_overrun <= 1'b1;
    end
  end

  assign res_count = r_res_count;
  assign res_sat   = r_res_sat;
  assign res_log2N = r_res_log2N;
  assign res_valid = r_res_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state == GATE);

endmodule

// File: tb/tb_freq_counter_pow2.sv
// Scoreboard bench for freq_counter_pow2: directed gate scenarios push expected results,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_freq_counter_pow2;

  localparam int N_CH = 2;
  localparam int CW   = 4;
  localparam int LW   = 6;
  localparam int LMAX = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [LW-1:0]        log2N;
  logic [N_CH-1:0]      sig_in = '0;
  logic [N_CH*CW-1:0]   res_count;
  logic [N_CH-1:0]      res_sat;
  logic [LW-1:0]        res_log2N;
  logic                 res_valid;
  logic                 res_ready;
  logic                 overrun;
  logic                 busy;

  freq_counter_pow2 #(
    .N_CH(N_CH), .CNT_WIDTH(CW), .LOG2N_WIDTH(LW), .LOG2N_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .log2N(log2N), .sig_in(sig_in),
    .res_count(res_count), .res_sat(res_sat), .res_log2N(res_log2N),
    .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c0;
    int         c1;
    logic [1:0] sat;
    int         lg;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pop_cyc[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   sum0   = 0;
  int   per [N_CH] = '{default: 0};
  int   ph  [N_CH] = '{default: 0};
  int   a;

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave generator: per[k] = period in clk (0 = hold low), starts high from phase 0.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (per[k] <= 0) begin
        sig_in[k] = 1'b0;
        ph[k]     = 0;
      end else begin
        sig_in[k] = (ph[k] < per[k] / 2);
        ph[k]     = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      pop_cyc.push_back(cyc);
      sum0 += int'(res_count[CW-1:0]);
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_result: got c0=%0d c1=%0d sat=%b lg=%0d, required no result",
                 res_count[CW-1:0], res_count[2*CW-1:CW], res_sat, res_log2N);
      end else begin
        e = q.pop_front();
        if (int'(res_count[CW-1:0]) == e.c0 && int'(res_count[2*CW-1:CW]) == e.c1 &&
            res_sat == e.sat && int'(res_log2N) == e.lg)
          n_pass++;
        else
          $display("FAIL result@%0d: got c0=%0d c1=%0d sat=%b lg=%0d, required c0=%0d c1=%0d sat=%b lg=%0d",
                   cyc, res_count[CW-1:0], res_count[2*CW-1:CW], res_sat, res_log2N,
                   e.c0, e.c1, e.sat, e.lg);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int c0, input int c1, input logic [1:0] s, input int lg);
    exp_t t;
    t.c0 = c0; t.c1 = c1; t.sat = s; t.lg = lg;
    q.push_back(t);
  endtask

  task automatic wait_empty(input string name, input int bound);
    int i = 0;
    while (q.size() != 0 && i < bound) begin
      @(posedge clk);
      i++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"},   int'(res_count), 0);
    chk({tag, "_sat"},     int'(res_sat),   0);
    chk({tag, "_log2N"},   int'(res_log2N), 0);
    chk({tag, "_valid"},   int'(res_valid), 0);
    chk({tag, "_overrun"}, int'(overrun),   0);
    chk({tag, "_busy"},    int'(busy),      0);
  endtask

  task automatic gap();
    enable = 1'b0;
    per[0] = 0;
    per[1] = 0;
    step(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; res_ready = 1'b1; log2N = '0;
    step(2);
    chk_zero("reset");
    rst = 1'b0;
    step(3);

    // Steady streams, 16-cycle gates: 4 and 2 edges per gate.
    log2N = 6'd4; per[0] = 4; per[1] = 8;
    step(20);
    repeat (3) push_exp(4, 2, 2'b00, 4);
    pop_cyc.delete();
    a = cyc;
    enable = 1'b1;
    chk("t1_busy_before", int'(busy), 0);
    step(1);
    chk("t1_busy_after", int'(busy), 1);
    wait_empty("t1_done", 80);
    chk("t1_first_latency", pop_cyc.size() > 0 ? pop_cyc[0] : -1, a + 17);
    step(1);
    gap();

    // One-cycle gates, edge every 2 clk: results 0,0,1,0,1,... across 99 gates.
    log2N = 6'd0; sum0 = 0;
    for (int j = 1; j <= 99; j++) push_exp((j >= 3 && j % 2 == 1) ? 1 : 0, 0, 2'b00, 0);
    per[0] = 2; enable = 1'b1;
    step(100);
    chk("t2_overrun", int'(overrun), 0);
    enable = 1'b0; per[0] = 0;
    wait_empty("t2_done", 20);
    chk("t2_total_edges", sum0, 49);
    step(1);
    gap();

    // 4-bit counters, 64-cycle gate with 31 edges saturates, next gate holds 5 edges.
    log2N = 6'd6;
    push_exp(15, 0, 2'b01, 6);
    push_exp(5, 0, 2'b00, 6);
    per[0] = 2; enable = 1'b1;
    step(62); per[0] = 0;
    step(8);  per[0] = 2;
    step(10); per[0] = 0;
    wait_empty("t3_done", 150);
    step(1);
    gap();

    // Oversized exponent clamps to LOG2N_MAX = 7 (128-cycle gate).
    log2N = 6'd35; per[0] = 16; per[1] = 32;
    step(40);
    push_exp(8, 4, 2'b00, 7);
    pop_cyc.delete();
    a = cyc;
    enable = 1'b1;
    wait_empty("t4_done", 200);
    chk("t4_clamp_latency", pop_cyc.size() > 0 ? pop_cyc[0] : -1, a + 129);
    step(1);
    gap();

    // log2N 3 -> 5 mid-gate: current gate still 8 cycles, next gate 32.
    log2N = 6'd3; per[0] = 4;
    step(12);
    push_exp(2, 0, 2'b00, 3);
    push_exp(8, 0, 2'b00, 5);
    pop_cyc.delete();
    a = cyc;
    enable = 1'b1;
    step(4);
    log2N = 6'd5;
    wait_empty("t5_done", 80);
    chk("t5_gate1_end", pop_cyc.size() > 0 ? pop_cyc[0] : -1, a + 9);
    chk("t5_gate2_end", pop_cyc.size() > 1 ? pop_cyc[1] : -1, a + 41);
    step(1);
    gap();

    // Overrun: two gates (3 then 1 edges) with ready low; second result must remain.
    log2N = 6'd3; res_ready = 1'b0;
    per[0] = 2; enable = 1'b1;
    step(8);  per[0] = 0;
    step(10);
    chk("t6_valid",   int'(res_valid), 1);
    chk("t6_overrun", int'(overrun),   1);
    chk("t6_count0",  int'(res_count[CW-1:0]), 1);
    chk("t6_count1",  int'(res_count[2*CW-1:CW]), 0);
    chk("t6_log2N",   int'(res_log2N), 3);
    enable = 1'b0;
    step(2);
    chk("t6_overrun_cleared", int'(overrun), 0);
    chk("t6_busy_cleared",    int'(busy),    0);
    push_exp(1, 0, 2'b00, 3);
    res_ready = 1'b1;
    step(1);
    chk("t6_valid_after_xfer", int'(res_valid), 0);
    step(10);
    chk("t6_no_partial_result", int'(res_valid), 0);
    chk("t6_queue_drained", q.size(), 0);
    gap();

    // Reset mid-gate with a pending result, then re-enable and time the first result.
    log2N = 6'd2; per[0] = 4; res_ready = 1'b0;
    step(10);
    enable = 1'b1;
    step(6);
    chk("t7_valid_before_rst", int'(res_valid), 1);
    rst = 1'b1; enable = 1'b0;
    #1;
    chk_zero("t7_rst");
    step(2);
    rst = 1'b0;
    step(6);
    res_ready = 1'b1;
    push_exp(1, 0, 2'b00, 2);
    pop_cyc.delete();
    a = cyc;
    enable = 1'b1;
    step(1);
    chk("t7_busy", int'(busy), 1);
    wait_empty("t7_done", 20);
    chk("t7_first_latency", pop_cyc.size() > 0 ? pop_cyc[0] : -1, a + 5);
    step(1);
    gap();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
